// File: rtl/comp_pkg.sv
// Shared definitions for the gate-exercise lab checkers: FSM state encoding,
// golden gate functions and a small popcount helper.
package comp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } estado_t;

    function automatic logic gold_xor(input logic [1:0] v);
        return v[1] ^ v[0];
    endfunction

    function automatic logic gold_and(input logic [1:0] v);
        return v[1] & v[0];
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/comprobador_compuertas_contador.sv
// Saturating error accumulator: clears on clr_i, otherwise adds a 3-bit
// increment when add_i is high and sticks at the all-ones maximum.
module contador_saturado #(
    parameter int ERR_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             add_i,
    input  logic [2:0]       inc_i,
    output logic [ERR_W-1:0] cuenta_o
);

    // Sum is wide enough for max count plus the largest increment.
    localparam int SUM_W = ((ERR_W > 3) ? ERR_W : 3) + 1;
    localparam logic [SUM_W-1:0] MAX_EXT = SUM_W'({ERR_W{1'b1}});

    logic [ERR_W-1:0] cuenta_q;
    logic [ERR_W-1:0] cuenta_d;
    logic [SUM_W-1:0] suma;

    always_comb begin
        suma     = SUM_W'(cuenta_q) + SUM_W'(inc_i);
        cuenta_d = cuenta_q;
        if (add_i) begin
            if (suma > MAX_EXT) begin
                cuenta_d = {ERR_W{1'b1}};
            end else begin
                cuenta_d = suma[ERR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cuenta_q <= '0;
        end else begin
            cuenta_q <= cuenta_d;
        end
    end

    assign cuenta_o = cuenta_q;

endmodule

// File: rtl/comprobador_compuertas.sv
// Response checker for the gate lab: sweeps all 2-bit vectors, samples the
// functional and NAND-structural XOR/AND outputs after a settle time and scores them.
module comprobador_compuertas
    import comp_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_SWEEPS    = 1,
    parameter int ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [1:0]       estimulo,
    input  logic [1:0]       rta_xor,
    input  logic [1:0]       rta_and,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_err_vec,
    output logic             first_err_valid,
    output logic [2:0]       estado_dbg_o
);

    localparam int SW    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int SWP_W = $clog2(NUM_SWEEPS + 1);
    localparam logic [SW-1:0]    SETTLE_LD  = SW'(SETTLE_CYCLES);
    localparam logic [SWP_W-1:0] LAST_SWEEP = SWP_W'(NUM_SWEEPS - 1);

    estado_t          estado_q;
    logic [1:0]       estimulo_q;
    logic [SWP_W-1:0] sweep_q;
    logic [SW-1:0]    settle_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [1:0]       first_err_vec_q;
    logic             first_err_valid_q;

    logic             gx;
    logic             ga;
    logic [3:0]       mism;
    logic [2:0]       n_mism;
    logic             acepta;
    logic             sumar;
    logic [ERR_W-1:0] cuenta;

    // start is a one-cycle request honoured only from IDLE or DONE; busy is
    // high for the whole run and done stays high until the next accepted start.
    always_comb begin
        gx     = gold_xor(estimulo_q);
        ga     = gold_and(estimulo_q);
        mism   = {rta_xor[1] != gx, rta_xor[0] != gx, rta_and[1] != ga, rta_and[0] != ga};
        n_mism = popcount4(mism);
        acepta = start && ((estado_q == ST_IDLE) || (estado_q == ST_DONE));
        sumar  = (estado_q == ST_SAMPLE);
    end

    contador_saturado #(
        .ERR_W(ERR_W)
    ) u_contador (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (acepta),
        .add_i   (sumar),
        .inc_i   (n_mism),
        .cuenta_o(cuenta)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q          <= ST_IDLE;
            estimulo_q        <= 2'b00;
            sweep_q           <= '0;
            settle_q          <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            first_err_vec_q   <= 2'b00;
            first_err_valid_q <= 1'b0;
        end else begin
            case (estado_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        done_q            <= 1'b0;
                        pass_q            <= 1'b0;
                        first_err_vec_q   <= 2'b00;
                        first_err_valid_q <= 1'b0;
                        estimulo_q        <= 2'b00;
                        sweep_q           <= '0;
                        busy_q            <= 1'b1;
                        estado_q          <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    settle_q <= SETTLE_LD;
                    estado_q <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_q > SW'(1)) begin
                        settle_q <= settle_q - SW'(1);
                    end else begin
                        estado_q <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if ((mism != 4'b0000) && !first_err_valid_q) begin
                        first_err_vec_q   <= estimulo_q;
                        first_err_valid_q <= 1'b1;
                    end
                    if ((estimulo_q == 2'b11) && (sweep_q == LAST_SWEEP)) begin
                        // Saturation never wraps, so zero now plus zero new errors means clean.
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        pass_q   <= (cuenta == '0) && (n_mism == 3'd0);
                        estado_q <= ST_DONE;
                    end else begin
                        if (estimulo_q == 2'b11) begin
                            sweep_q <= sweep_q + SWP_W'(1);
                        end
                        estimulo_q <= estimulo_q + 2'b01;
                        estado_q   <= ST_DRIVE;
                    end
                end
                default: estado_q <= ST_IDLE;
            endcase
        end
    end

    assign estimulo        = estimulo_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_count       = cuenta;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;
    assign estado_dbg_o    = estado_q;

endmodule

// File: tb/tb_comprobador_compuertas.sv
// Bench for comprobador_compuertas: four instances with different parameter
// sets, gate responses built from per-bit fault modes, scored against a sweep model.
module tb_comprobador_compuertas;
    import comp_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [4];
    logic [1:0] est [4];
    logic [1:0] rx [4];
    logic [1:0] ra [4];
    logic       busy [4];
    logic       done [4];
    logic       pass [4];
    logic [1:0] fvec [4];
    logic       fvalid [4];
    logic [2:0] st_dbg [4];
    logic [7:0] ec0, ec1, ec3;
    logic [1:0] ec2;

    // Fault mode per response bit, 2 bits each: [1:0] xor[0], [3:2] xor[1],
    // [5:4] and[0], [7:6] and[1]; 0 ideal, 1 inverted, 2 stuck-0, 3 stuck-1.
    logic [7:0] fm [4];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic flt(input logic g, input logic [1:0] m);
        case (m)
            2'd0:    return g;
            2'd1:    return ~g;
            2'd2:    return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_resp
        assign rx[g] = {flt(est[g][0] ^ est[g][1], fm[g][3:2]), flt(est[g][0] ^ est[g][1], fm[g][1:0])};
        assign ra[g] = {flt(est[g][0] & est[g][1], fm[g][7:6]), flt(est[g][0] & est[g][1], fm[g][5:4])};
    end

    comprobador_compuertas #(.SETTLE_CYCLES(2), .NUM_SWEEPS(1), .ERR_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start[0]), .estimulo(est[0]), .rta_xor(rx[0]), .rta_and(ra[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(ec0), .first_err_vec(fvec[0]),
        .first_err_valid(fvalid[0]), .estado_dbg_o(st_dbg[0]));

    comprobador_compuertas #(.SETTLE_CYCLES(2), .NUM_SWEEPS(2), .ERR_W(8)) u_b (
        .clk(clk), .rst(rst), .start(start[1]), .estimulo(est[1]), .rta_xor(rx[1]), .rta_and(ra[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(ec1), .first_err_vec(fvec[1]),
        .first_err_valid(fvalid[1]), .estado_dbg_o(st_dbg[1]));

    comprobador_compuertas #(.SETTLE_CYCLES(2), .NUM_SWEEPS(1), .ERR_W(2)) u_c (
        .clk(clk), .rst(rst), .start(start[2]), .estimulo(est[2]), .rta_xor(rx[2]), .rta_and(ra[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(ec2), .first_err_vec(fvec[2]),
        .first_err_valid(fvalid[2]), .estado_dbg_o(st_dbg[2]));

    comprobador_compuertas #(.SETTLE_CYCLES(0), .NUM_SWEEPS(1), .ERR_W(8)) u_d (
        .clk(clk), .rst(rst), .start(start[3]), .estimulo(est[3]), .rta_xor(rx[3]), .rta_and(ra[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(ec3), .first_err_vec(fvec[3]),
        .first_err_valid(fvalid[3]), .estado_dbg_o(st_dbg[3]));

    function automatic int cfg_s(input int d);
        return (d == 3) ? 0 : 2;
    endfunction

    function automatic int cfg_n(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic int cfg_e(input int d);
        return (d == 2) ? 2 : 8;
    endfunction

    function automatic int get_err(input int d);
        case (d)
            0:       return int'(ec0);
            1:       return int'(ec1);
            2:       return int'(ec2);
            default: return int'(ec3);
        endcase
    endfunction

    // Reference: walk every vector of every sweep, count wrong response bits, clamp.
    function automatic void model(input int d, output int e_ec, output logic [1:0] e_fv, output logic e_fva);
        int maxv;
        int m;
        logic [1:0] v;
        logic gx, ga;
        maxv  = (1 << cfg_e(d)) - 1;
        e_ec  = 0;
        e_fv  = 2'b00;
        e_fva = 1'b0;
        for (int s = 0; s < cfg_n(d); s++) begin
            for (int k = 0; k < 4; k++) begin
                v  = 2'(k);
                gx = (k == 1) || (k == 2);
                ga = (k == 3);
                m  = 0;
                if (flt(gx, fm[d][1:0]) != gx) m++;
                if (flt(gx, fm[d][3:2]) != gx) m++;
                if (flt(ga, fm[d][5:4]) != ga) m++;
                if (flt(ga, fm[d][7:6]) != ga) m++;
                e_ec = (e_ec + m > maxv) ? maxv : e_ec + m;
                if (m > 0 && !e_fva) begin
                    e_fv  = v;
                    e_fva = 1'b1;
                end
            end
        end
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL u%0d_%s: observed=%0h expected=%0h", d, name, obs, exp);
        end
    endtask

    task automatic chk_rst(input int d);
        chk(d, "rst_estimulo", 32'(est[d]), 0);
        chk(d, "rst_busy", 32'(busy[d]), 0);
        chk(d, "rst_done", 32'(done[d]), 0);
        chk(d, "rst_pass", 32'(pass[d]), 0);
        chk(d, "rst_err", get_err(d), 0);
        chk(d, "rst_fvec", 32'(fvec[d]), 0);
        chk(d, "rst_fvalid", 32'(fvalid[d]), 0);
        chk(d, "rst_state", 32'(st_dbg[d]), 32'(ST_IDLE));
    endtask

    // Edge 0 is the one that samples start; done must first show after edge 4*N*(S+2).
    task automatic run_check(input int d, input bit poke_busy);
        int p, exp_lat, limit, n, done_at, e_ec;
        logic [1:0] e_fv;
        logic e_fva;
        p       = cfg_s(d) + 2;
        exp_lat = 4 * cfg_n(d) * p;
        limit   = exp_lat + 8;
        model(d, e_ec, e_fv, e_fva);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        n       = 0;
        done_at = -1;
        while (n <= limit) begin
            if (n == 0) begin
                chk(d, "busy_rise", 32'(busy[d]), 1);
                chk(d, "done_drop", 32'(done[d]), 0);
            end
            if (n < exp_lat && (n % p) == 0) chk(d, "estimulo", 32'(est[d]), (n / p) % 4);
            if (done[d]) begin
                done_at = n;
                break;
            end
            start[d] = poke_busy && (n == 3);
            @(posedge clk);
            #1;
            n++;
        end
        start[d] = 1'b0;
        chk(d, "done_latency", done_at, exp_lat);
        chk(d, "err_count", get_err(d), e_ec);
        chk(d, "pass", 32'(pass[d]), (e_ec == 0) ? 1 : 0);
        chk(d, "fvalid", 32'(fvalid[d]), 32'(e_fva));
        chk(d, "fvec", 32'(fvec[d]), 32'(e_fv));
        chk(d, "busy_fall", 32'(busy[d]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            start[d] = 1'b0;
            fm[d]    = 8'h00;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) chk_rst(d);
        @(negedge clk);
        rst = 1'b0;

        // Ideal gates, default parameters.
        run_check(0, 1'b0);

        // and[1] stuck at 1: errors at 00, 01, 10.
        fm[0] = 8'hC0;
        run_check(0, 1'b0);
        chk(0, "stuck_err3", get_err(0), 3);

        // xor[0] inverted over two sweeps.
        fm[1] = 8'h01;
        run_check(1, 1'b0);
        chk(1, "inv_err8", get_err(1), 8);

        // Everything inverted on a 2-bit counter: saturates and holds.
        fm[2] = 8'h55;
        run_check(2, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk(2, "sat_hold", get_err(2), 3);

        // No settle time, plus a start pulse while busy.
        run_check(3, 1'b1);

        // Restart from DONE with clean gates: counters and flags cleared.
        fm[0] = 8'h00;
        run_check(0, 1'b0);

        // Reset while 10 is settling.
        fm[0] = 8'hC0;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk(0, "pre_rst_vec", 32'(est[0]), 2);
        chk(0, "pre_rst_err", get_err(0), 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_rst(0);
        @(negedge clk);
        rst = 1'b0;
        fm[0] = 8'h00;
        run_check(0, 1'b0);

        // Random fault mixes on every instance.
        for (int r = 0; r < 6; r++) begin
            for (int d = 0; d < 4; d++) begin
                fm[d] = 8'($urandom_range(0, 255));
                run_check(d, 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
